// File: rtl/wb_regfile.sv
// Writeback select plus 32-entry architectural register file with two async read ports.
// Optional same-cycle write-to-read bypass: define WB_REGFILE_BYPASS_EN.
module wb_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic [DATA_W-1:0] wb_mem_data,
  input  logic [ADDR_W-1:0] wb_rd,
  input  logic              wb_regwrite,
  input  logic [DATA_W-1:0] wb_alu_result,
  input  logic              wb_memtoreg,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_commit
);

  localparam int NUM_REGS = 2 ** ADDR_W;

  // Entry 0 has no storage; it is synthesised as a constant zero on reads.
  logic [DATA_W-1:0] regs_reg [1:NUM_REGS-1];
  logic [NUM_REGS-1:1] wr_en;
  logic [DATA_W-1:0] rs_store;
  logic [DATA_W-1:0] rt_store;

  assign wb_data   = wb_memtoreg ? wb_mem_data : wb_alu_result;
  assign wb_commit = resetn & wb_regwrite & (wb_rd != '0);

  genvar gi;
  generate
    for (gi = 1; gi < NUM_REGS; gi++) begin : g_wr_dec
      assign wr_en[gi] = wb_commit && (wb_rd == ADDR_W'(gi));
    end
  endgenerate

  // Reset takes priority over a write presented on the same edge.
  always_ff @(posedge clock) begin
    for (int i = 1; i < NUM_REGS; i++) begin
      if (!resetn) begin
        regs_reg[i] <= '0;
      end else if (wr_en[i]) begin
        regs_reg[i] <= wb_data;
      end
    end
  end

  always_comb begin
    rs_store = '0;
    rt_store = '0;
    if (rs_addr != '0) rs_store = regs_reg[rs_addr];
    if (rt_addr != '0) rt_store = regs_reg[rt_addr];
  end

`ifdef WB_REGFILE_BYPASS_EN
  // wb_commit is already low for index 0, so r0 can never be bypassed.
  assign rs_data = (wb_commit && (wb_rd == rs_addr)) ? wb_data : rs_store;
  assign rt_data = (wb_commit && (wb_rd == rt_addr)) ? wb_data : rt_store;
`else
  assign rs_data = rs_store;
  assign rt_data = rt_store;
`endif

endmodule

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for wb_regfile; expectations adapt to WB_REGFILE_BYPASS_EN.
module tb_wb_regfile;

  logic        clock;
  logic        resetn;
  logic [31:0] wb_mem_data;
  logic [4:0]  wb_rd;
  logic        wb_regwrite;
  logic [31:0] wb_alu_result;
  logic        wb_memtoreg;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [31:0] wb_data;
  logic        wb_commit;

  int errors = 0;
  int checks = 0;

  wb_regfile #(.DATA_W(32), .ADDR_W(5)) dut (
    .clock         (clock),
    .resetn        (resetn),
    .wb_mem_data   (wb_mem_data),
    .wb_rd         (wb_rd),
    .wb_regwrite   (wb_regwrite),
    .wb_alu_result (wb_alu_result),
    .wb_memtoreg   (wb_memtoreg),
    .rs_addr       (rs_addr),
    .rt_addr       (rt_addr),
    .rs_data       (rs_data),
    .rt_data       (rt_data),
    .wb_data       (wb_data),
    .wb_commit     (wb_commit)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %-22s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Inputs change #1 after the edge, checks are taken #2 after that.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic alu_write(input logic [4:0] rd, input logic [31:0] val);
    wb_regwrite   = 1'b1;
    wb_memtoreg   = 1'b0;
    wb_rd         = rd;
    wb_alu_result = val;
  endtask

  logic [31:0] bypass_exp;

  initial begin
    resetn        = 1'b0;
    wb_mem_data   = '0;
    wb_rd         = '0;
    wb_regwrite   = 1'b0;
    wb_alu_result = '0;
    wb_memtoreg   = 1'b0;
    rs_addr       = '0;
    rt_addr       = '0;

    tick();
    tick();
    rs_addr = 5'd5;
    rt_addr = 5'd31;
    alu_write(5'd5, 32'h1111_1111);
    settle();
    check("rst_rs_r5", rs_data, 32'h0);
    check("rst_rt_r31", rt_data, 32'h0);
    check("commit_low_in_rst", {31'b0, wb_commit}, 32'h0);
    check("wb_data_in_rst", wb_data, 32'h1111_1111);

    // Preload r5, then reset must clear it.
    tick();
    resetn = 1'b1;
    alu_write(5'd5, 32'hDEAD_BEEF);
    settle();
    check("preload_commit", {31'b0, wb_commit}, 32'h1);
    tick();
    wb_regwrite = 1'b0;
    settle();
    check("preload_r5", rs_data, 32'hDEAD_BEEF);
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    settle();
    check("reset_clears_r5", rs_data, 32'h0);

    // ALU writeback to r7.
    alu_write(5'd7, 32'h0000_1234);
    settle();
    check("alu_commit", {31'b0, wb_commit}, 32'h1);
    check("alu_wb_data", wb_data, 32'h0000_1234);
    tick();
    wb_regwrite = 1'b0;
    rt_addr = 5'd7;
    settle();
    check("alu_r7", rt_data, 32'h0000_1234);

    // Load to r0 is discarded and never bypassed.
    wb_regwrite = 1'b1;
    wb_memtoreg = 1'b1;
    wb_mem_data = 32'hCAFE_F00D;
    wb_rd       = 5'd0;
    rs_addr     = 5'd0;
    settle();
    check("r0_commit_low", {31'b0, wb_commit}, 32'h0);
    check("load_wb_data", wb_data, 32'hCAFE_F00D);
    check("r0_no_bypass", rs_data, 32'h0);
    tick();
    wb_rd = 5'd8;
    settle();
    check("r0_after_edge", rs_data, 32'h0);
    tick();
    wb_regwrite = 1'b0;
    rs_addr = 5'd8;
    settle();
    check("load_r8", rs_data, 32'hCAFE_F00D);

    // Same-cycle write/read of r3.
    alu_write(5'd3, 32'h1);
    tick();
    alu_write(5'd3, 32'h2);
    rs_addr = 5'd3;
    rt_addr = 5'd3;
`ifdef WB_REGFILE_BYPASS_EN
    bypass_exp = 32'h2;
`else
    bypass_exp = 32'h1;
`endif
    settle();
    check("bypass_rs_r3", rs_data, bypass_exp);
    check("bypass_rt_r3", rt_data, bypass_exp);
    tick();
    wb_regwrite = 1'b0;
    settle();
    check("post_edge_r3", rs_data, 32'h2);

    // Reset beats a simultaneous write to r9.
    alu_write(5'd9, 32'hFFFF_FFFF);
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    wb_regwrite = 1'b0;
    rs_addr = 5'd9;
    rt_addr = 5'd7;
    settle();
    check("rst_prio_r9", rs_data, 32'h0);
    check("rst_clears_r7", rt_data, 32'h0);

    // First edge after reset release performs a normal write.
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    alu_write(5'd10, 32'h0000_0055);
    tick();
    wb_regwrite = 1'b0;
    rs_addr = 5'd10;
    settle();
    check("first_edge_write_r10", rs_data, 32'h0000_0055);

    // Dual read of r4 and a non-write to r4.
    alu_write(5'd4, 32'hA5A5_A5A5);
    tick();
    wb_regwrite = 1'b0;
    rs_addr = 5'd4;
    rt_addr = 5'd4;
    settle();
    check("dual_rs_r4", rs_data, 32'hA5A5_A5A5);
    check("dual_rt_r4", rt_data, 32'hA5A5_A5A5);
    wb_rd = 5'd4;
    wb_alu_result = 32'h0;
    settle();
    check("no_we_commit", {31'b0, wb_commit}, 32'h0);
    tick();
    settle();
    check("no_we_r4", rs_data, 32'hA5A5_A5A5);

    // Unknown destination with write disabled.
    wb_rd = 5'bx;
    rt_addr = 5'd10;
    settle();
    check("x_rd_commit", {31'b0, wb_commit}, 32'h0);
    tick();
    settle();
    check("x_rd_r4", rs_data, 32'hA5A5_A5A5);
    check("x_rd_r10", rt_data, 32'h0000_0055);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
